// File: rtl/sensor_packetizer_if.sv
// Sample-in / UART-byte-out signal bundle for sensor_packetizer.
// slave is the packetizer's view; master is the sample source plus uart_send side.
interface sensor_packetizer_if;
   logic [7:0] cc_value;
   logic [7:0] dc_value;
   logic       sample_valid;
   logic       uart_ready;
   logic [7:0] data_byte;
   logic       start_send;
   logic       busy;
   logic [7:0] drop_count;

   modport slave (
      input  cc_value, dc_value, sample_valid, uart_ready,
      output data_byte, start_send, busy, drop_count
   );

   modport master (
      output cc_value, dc_value, sample_valid, uart_ready,
      input  data_byte, start_send, busy, drop_count
   );
endinterface

// File: rtl/sensor_packetizer.sv
// Frames each sample into sync/seq/cc/dc/checksum bytes and paces them into uart_send.
// First start_send 3 clk after sample_valid; samples arriving while busy are dropped and counted.
module sensor_packetizer #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input logic                i_clk,
   input logic                i_reset,
   sensor_packetizer_if.slave io
);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_NEXT
   } state_t;

   state_t        r_state;
   logic [7:0]    r_cc_snap;
   logic [7:0]    r_dc_snap;
   logic [7:0]    r_seq;
   logic [7:0]    r_data_byte;
   logic [7:0]    r_drop_count;
   logic [2:0]    r_byte_idx;
   logic [TW-1:0] r_tmo;
   logic          r_start_send;
   logic          r_busy;

   logic [7:0]    w_checksum;
   logic [7:0]    w_byte_mux;
   logic          w_drop;

   assign w_checksum = r_seq + r_cc_snap + r_dc_snap;
   assign w_drop     = io.sample_valid && (r_state != S_IDLE);

   always_comb begin
      w_byte_mux = SYNC_BYTE;
      case (r_byte_idx)
         3'd1:    w_byte_mux = r_seq;
         3'd2:    w_byte_mux = r_cc_snap;
         3'd3:    w_byte_mux = r_dc_snap;
         3'd4:    w_byte_mux = w_checksum;
         default: w_byte_mux = SYNC_BYTE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_cc_snap    <= 8'd0;
         r_dc_snap    <= 8'd0;
         r_seq        <= 8'd0;
         r_data_byte  <= 8'd0;
         r_drop_count <= 8'd0;
         r_byte_idx   <= 3'd0;
         r_tmo        <= '0;
         r_start_send <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_start_send <= 1'b0;
         if (w_drop && (r_drop_count != 8'hFF))
            r_drop_count <= r_drop_count + 8'd1;

         case (r_state)
            S_IDLE: begin
               if (io.sample_valid) begin
                  r_cc_snap  <= io.cc_value;
                  r_dc_snap  <= io.dc_value;
                  r_busy     <= 1'b1;
                  r_byte_idx <= 3'd0;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_data_byte <= w_byte_mux;
               r_state     <= S_START;
            end
            S_START: begin
               if (io.uart_ready) begin
                  r_start_send <= 1'b1;
                  r_tmo        <= '0;
                  r_state      <= S_WAIT_LOW;
               end
            end
            S_WAIT_LOW: begin
               // uart_send may never show busy for this byte; give up after the timeout
               if (!io.uart_ready)
                  r_state <= S_WAIT_HIGH;
               else if (r_tmo == TW'(BUSY_TIMEOUT - 1))
                  r_state <= S_NEXT;
               else
                  r_tmo <= r_tmo + TW'(1);
            end
            S_WAIT_HIGH: begin
               if (io.uart_ready)
                  r_state <= S_NEXT;
            end
            S_NEXT: begin
               if (r_byte_idx == 3'd4) begin
                  r_seq   <= r_seq + 8'd1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_byte_idx <= r_byte_idx + 3'd1;
                  r_state    <= S_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io.data_byte  = r_data_byte;
   assign io.start_send = r_start_send;
   assign io.busy       = r_busy;
   assign io.drop_count = r_drop_count;
endmodule

// File: tb/tb_sensor_packetizer.sv
// Randomized scoreboard bench for sensor_packetizer with a behavioural uart_send responder.
module tb_sensor_packetizer;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sensor_packetizer_if sp_if ();

   sensor_packetizer #(.SYNC_BYTE(8'hA5), .BUSY_TIMEOUT(TMO)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io      (sp_if)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] sb[$];
   int         sb_pos  = 0;
   int         last_ss = 0;
   logic       prev_ss = 1'b0;
   logic [7:0] m_seq   = 8'd0;
   int         m_drops = 0;
   int         uart_mode = 0;
   int         lo_dly  = 2;
   int         hi_dur  = 10;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference packet: sync, seq, cc, dc, (seq+cc+dc) mod 256
   task automatic push_packet(input logic [7:0] cc, input logic [7:0] dc);
      int s;
      s = (int'(m_seq) + int'(cc) + int'(dc)) % 256;
      sb.push_back(8'hA5);
      sb.push_back(m_seq);
      sb.push_back(cc);
      sb.push_back(dc);
      sb.push_back(8'(s));
      m_seq = 8'((int'(m_seq) + 1) % 256);
   endtask

   task automatic send_sample(input logic [7:0] cc, input logic [7:0] dc);
      sp_if.cc_value     = cc;
      sp_if.dc_value     = dc;
      sp_if.sample_valid = 1'b1;
      tick;
      sp_if.sample_valid = 1'b0;
      push_packet(cc, dc);
      chk("busy_after_accept", int'(sp_if.busy), 1);
   endtask

   task automatic drop_pulse;
      sp_if.cc_value     = 8'($urandom_range(0, 255));
      sp_if.dc_value     = 8'($urandom_range(0, 255));
      sp_if.sample_valid = 1'b1;
      tick;
      sp_if.sample_valid = 1'b0;
      m_drops = (m_drops < 255) ? m_drops + 1 : 255;
   endtask

   task automatic wait_idle(input bit scramble);
      int n;
      n = 0;
      while (sp_if.busy && n < 3000) begin
         if (scramble) begin
            sp_if.cc_value = 8'($urandom_range(0, 255));
            sp_if.dc_value = 8'($urandom_range(0, 255));
         end
         tick;
         n++;
      end
      chk("busy_falls", int'(sp_if.busy), 0);
      chk("sb_drained", sb.size(), 0);
      chk("drop_count", int'(sp_if.drop_count), m_drops);
      chk("start_idle", int'(sp_if.start_send), 0);
   endtask

   // Monitor: every start_send pops one expected byte
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ss = 1'b0;
         end else begin
            if (sp_if.start_send) begin
               chk("start_pulse_width", int'(prev_ss), 0);
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_byte: got %0h with nothing expected", sp_if.data_byte);
               end else begin
                  e = sb.pop_front();
                  chk("byte", int'(sp_if.data_byte), int'(e));
               end
               if (uart_mode == 1 && sb_pos != 0)
                  chk("timeout_spacing", cyc - last_ss, TMO + 3);
               last_ss = cyc;
               sb_pos  = (sb_pos + 1) % 5;
            end
            prev_ss = sp_if.start_send;
         end
      end
   end

   // uart_send responder: ready falls lo_dly cycles after start_send, rises hi_dur later
   initial begin
      sp_if.uart_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && sp_if.start_send && uart_mode == 0) begin
            repeat (lo_dly) @(posedge clk);
            #1 sp_if.uart_ready = 1'b0;
            repeat (hi_dur) @(posedge clk);
            #1 sp_if.uart_ready = 1'b1;
         end
      end
   end

   initial begin
      #2_000_000;
      n_errors++;
      $display("FAIL watchdog: run did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      sp_if.cc_value     = 8'd0;
      sp_if.dc_value     = 8'd0;
      sp_if.sample_valid = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_data_byte", int'(sp_if.data_byte), 0);
      chk("rst_start_send", int'(sp_if.start_send), 0);
      chk("rst_busy", int'(sp_if.busy), 0);
      chk("rst_drop_count", int'(sp_if.drop_count), 0);
      @(negedge clk);
      rst = 1'b0;
      tick;

      // basic packet with latency check
      send_sample(8'h12, 8'h34);
      tick;
      chk("latency_early", int'(sp_if.start_send), 0);
      tick;
      chk("latency_first_start", int'(sp_if.start_send), 1);
      wait_idle(0);

      // overrun: three strobes mid-packet with different values
      send_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat (4) tick;
      drop_pulse;
      repeat (10) tick;
      drop_pulse;
      repeat (15) tick;
      drop_pulse;
      wait_idle(0);
      chk("overrun_count", int'(sp_if.drop_count), 3);

      // random packets, inputs scrambled every cycle, occasional early overruns
      for (int p = 0; p < 20; p++) begin
         lo_dly = $urandom_range(1, 5);
         hi_dur = $urandom_range(1, 12);
         send_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 7) == 0) begin
               drop_pulse;
            end else begin
               sp_if.cc_value = 8'($urandom_range(0, 255));
               sp_if.dc_value = 8'($urandom_range(0, 255));
               tick;
            end
         end
         wait_idle(1);
      end

      // uart never drops ready: every byte goes through the timeout
      uart_mode = 1;
      send_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_idle(1);
      uart_mode = 0;

      // reset while byte 2 is in WAIT_HIGH
      lo_dly = 2;
      hi_dur = 10;
      send_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      n = 0;
      while (sb_pos != 3 && n < 1000) begin
         tick;
         n++;
      end
      chk("reached_byte2", sb_pos, 3);
      repeat (5) tick;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_data_byte", int'(sp_if.data_byte), 0);
      chk("arst_start_send", int'(sp_if.start_send), 0);
      chk("arst_busy", int'(sp_if.busy), 0);
      chk("arst_drop_count", int'(sp_if.drop_count), 0);
      sb.delete();
      sb_pos  = 0;
      m_seq   = 8'd0;
      m_drops = 0;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!sp_if.uart_ready && n < 100) begin
         tick;
         n++;
      end
      tick;
      send_sample(8'h01, 8'h02);
      wait_idle(0);

      // 257 packets across the seq wrap; 300 overruns saturate drop_count
      lo_dly = 1;
      hi_dur = 1;
      for (int p = 0; p < 257; p++) begin
         send_sample(8'hFF, 8'h01);
         if (p < 150) begin
            tick;
            drop_pulse;
            tick;
            drop_pulse;
         end
         wait_idle(0);
      end
      chk("drop_saturated", int'(sp_if.drop_count), 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sensor_packetizer.md
Name: sensor_packetizer

Overview:
- Sits between the measurement stages (ring-oscillator frequency counter and duty-cycle circuit) and the shared uart_send transmitter.
- On each sample strobe, snapshots the counter value and the duty-cycle value.
- Frames them into a 5-byte packet: sync, sequence, cc, dc, checksum.
- Feeds the bytes one at a time to uart_send using its start_send/ready handshake.
- Replaces the free-running start_send=1 hookup so the host can align to packet boundaries.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- BUSY_TIMEOUT, 16, cycles to wait for uart_ready to fall after start_send before treating the byte as accepted.

Ports:
- clk  input  1  system clock (same domain as uart_send).
- reset  input  1  asynchronous, active-high reset.
- cc_value  input  8  frequency-counter result.
- dc_value  input  8  duty-cycle result.
- sample_valid  input  1  one-cycle strobe: new sample available.
- uart_ready  input  1  from uart_send; high = transmitter idle.
- data_byte  output  8  byte presented to uart_send.
- start_send  output  1  one-cycle request to uart_send.
- busy  output  1  high while a packet is in flight.
- drop_count  output  8  saturating count of samples dropped while busy.

Behaviour:
- Reset: all regs cleared asynchronously.
  - data_byte=0, start_send=0, busy=0, drop_count=0.
  - seq=0, byte_idx=0, state=IDLE.
- States:
  - IDLE: on sample_valid, register cc_value/dc_value into snapshot regs, set busy=1, byte_idx=0 -> LOAD.
  - LOAD: drive data_byte from byte_idx, then -> START.
    - Byte order: 0=SYNC_BYTE, 1=seq, 2=cc_snap, 3=dc_snap, 4=checksum.
  - START: wait for uart_ready=1. On that cycle assert start_send for exactly one clk, clear the timeout counter -> WAIT_LOW.
  - WAIT_LOW: wait for uart_ready=0 -> WAIT_HIGH.
    - If the timeout counter reaches BUSY_TIMEOUT first, go to NEXT.
  - WAIT_HIGH: wait for uart_ready=1 -> NEXT.
  - NEXT: if byte_idx==4, set seq<=seq+1 (wraps 255->0), busy<=0 -> IDLE. Otherwise byte_idx+1 -> LOAD.
- Checksum: (seq + cc_snap + dc_snap) mod 256, computed from the snapshot, excluding the sync byte.
- data_byte is held stable from LOAD until the next LOAD.
- start_send is never asserted in more than one consecutive cycle.
- Overrun: sample_valid while busy=1, including the NEXT cycle of byte 4, is dropped.
  - The snapshot is not updated.
  - drop_count increments and saturates at 255.
- sample_valid coincident with the IDLE entry cycle: the sample is not lost. A sample arriving in the cycle IDLE is entered is accepted on the next cycle if still asserted; the strobe itself is only sampled in IDLE.
- Inputs cc_value/dc_value may change freely after the snapshot; packet contents do not change mid-packet.
- Reset mid-packet:
  - Transmission aborts immediately and start_send drops.
  - seq returns to 0.
  - A byte already handed to uart_send may still finish on the line; the host resynchronises on SYNC_BYTE.
- Minimum packet latency: sample_valid to first start_send = 3 clk (IDLE->LOAD->START, with uart_ready already high).

Test Plan:
- Basic packet:
  - Stimulus: after reset, cc_value=8'h12, dc_value=8'h34, single sample_valid pulse; uart model drops ready 2 cycles after start_send and raises it 10 cycles later.
  - Required response: bytes A5 00 12 34 46 in order, five start_send pulses each one cycle wide, busy falls after the fifth byte, seq=1.
- Sequence wrap and checksum wrap:
  - Stimulus: 256 packets with cc=8'hFF, dc=8'h01.
  - Required response: packet 255 has seq=FF and checksum=(FF+FF+01) mod 256 = FF; the next packet has seq=00 and checksum=00.
- Overrun:
  - Stimulus: three sample_valid pulses during one packet.
  - Required response: drop_count=3, packet contents unchanged. Separately, 300 drops leave drop_count saturated at 255.
- Timeout:
  - Stimulus: uart_ready held high permanently.
  - Required response: each byte advances BUSY_TIMEOUT+3 cycles after the previous LOAD; the full packet completes with no hang.
- Reset mid-packet:
  - Stimulus: assert reset during byte 2's WAIT_HIGH, release, then send a new sample with cc=01, dc=02.
  - Required response: outputs go to 0 asynchronously (checked between clock edges); the next packet is A5 00 01 02 03.
- Input change during packet:
  - Stimulus: change cc_value/dc_value every cycle after the accepting sample_valid.
  - Required response: the packet carries the values present on the accept cycle.
